// File: rtl/fetch_line_if.sv
// Fetch line controller bus bundle: fetch-stage side (pc, fetch_en, prmiss, inv,
// idata, idata_valid) and memory line-read side (mem_req, mem_addr, mem_ack,
// mem_rdata, fetch_err). slave = controller view, master = fetch/memory view.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif

interface fetch_line_if #(
  parameter int ADDR_LEN = `ADDR_LEN
) ();
  logic [ADDR_LEN-1:0] pc;
  logic                fetch_en;
  logic                prmiss;
  logic                inv;
  logic [127:0]        idata;
  logic                idata_valid;
  logic                mem_req;
  logic [ADDR_LEN-1:0] mem_addr;
  logic                mem_ack;
  logic [127:0]        mem_rdata;
  logic                fetch_err;

  modport slave (
    input  pc, fetch_en, prmiss, inv, mem_ack, mem_rdata,
    output idata, idata_valid, mem_req, mem_addr, fetch_err
  );

  modport master (
    output pc, fetch_en, prmiss, inv, mem_ack, mem_rdata,
    input  idata, idata_valid, mem_req, mem_addr, fetch_err
  );
endinterface

// File: rtl/fetch_line_ctrl.sv
// One-entry instruction line buffer with a single outstanding memory line read.
// Latency: miss seen at cycle 0, mem_req at +1, earliest ack at +2, idata_valid at +3.
// Backpressure: mem_req held with stable mem_addr until the single-cycle mem_ack.
// Ports: clk, reset (async active-low), fl (fetch_line_if.slave: pc/fetch_en/
// prmiss/inv in, idata/idata_valid out, mem_req/mem_addr out, mem_ack/mem_rdata
// in, fetch_err out).
// Optional macro FETCH_TIMEOUT_EN: abandon a fetch after TIMEOUT_CYC wait cycles
// and pulse fetch_err; without it the block waits forever and fetch_err is 0.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif

module fetch_line_ctrl #(
  parameter int ADDR_LEN    = `ADDR_LEN,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic           clk,
  input  logic           reset,
  fetch_line_if.slave    fl
);

  localparam int TAG_W = ADDR_LEN - 4;

  // The wait counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;

  state_t               state_q, state_d;
  logic                 buf_v_q, buf_v_d;
  logic [TAG_W-1:0]     buf_tag_q, buf_tag_d;
  logic [127:0]         buf_data_q, buf_data_d;
  logic                 req_q, req_d;
  logic [ADDR_LEN-1:0]  addr_q, addr_d;

  logic [TAG_W-1:0]     pc_tag;
  logic                 hit;
  logic                 timed_out;

  // Offset bits within the line do not affect the buffer.
  logic unused_pc_lo;
  assign unused_pc_lo = ^fl.pc[3:0];

  assign pc_tag = fl.pc[ADDR_LEN-1:4];
  // A redirect or invalidate in this cycle means the line cannot be trusted yet.
  assign hit    = buf_v_q && (buf_tag_q == pc_tag) && !fl.prmiss && !fl.inv;

  assign fl.idata       = buf_data_q;
  assign fl.idata_valid = hit;
  assign fl.mem_req     = req_q;
  assign fl.mem_addr    = addr_q;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] wait_cnt_q;
  logic       err_q;

  // Fires on the edge where the counter would reach TIMEOUT_CYC, so the
  // fetch_err pulse lands exactly TIMEOUT_CYC cycles after BUSY entry.
  assign timed_out = (state_q != IDLE) && !fl.mem_ack && (wait_cnt_q == WAIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      err_q <= timed_out;
      // Held at zero while idle, which clears it on entry to BUSY.
      if (state_q == IDLE) begin
        wait_cnt_q <= 8'd0;
      end else if (!fl.mem_ack) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
    end
  end

  assign fl.fetch_err = err_q;
`else
  assign timed_out    = 1'b0;
  assign fl.fetch_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    buf_v_d    = buf_v_q;
    buf_tag_d  = buf_tag_q;
    buf_data_d = buf_data_q;
    req_d      = req_q;
    addr_d     = addr_q;

    case (state_q)
      IDLE: begin
        // mem_ack is ignored here: it can only be a stale response.
        if (fl.fetch_en && !hit && !fl.prmiss && !fl.inv) begin
          state_d = BUSY;
          req_d   = 1'b1;
          addr_d  = {pc_tag, 4'b0000};
        end
      end
      BUSY, DROP: begin
        if (fl.mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          // The line is tagged by its own address, so a redirect in the ack
          // cycle still leaves correct data; only DROP discards it.
          if (state_q == BUSY) begin
            buf_data_d = fl.mem_rdata;
            buf_tag_d  = addr_q[ADDR_LEN-1:4];
            buf_v_d    = 1'b1;
          end
        end else if (timed_out) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else if (fl.prmiss || fl.inv) begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    // Invalidate wins over a fill landing in the same cycle.
    if (fl.inv) begin
      buf_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      buf_v_q    <= 1'b0;
      buf_tag_q  <= '0;
      buf_data_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      buf_v_q    <= buf_v_d;
      buf_tag_q  <= buf_tag_d;
      buf_data_q <= buf_data_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_line_ctrl.sv
// Bench for fetch_line_ctrl: directed scenarios plus randomized traffic, all
// checked against a transaction-level model (buffer + one outstanding request).
`timescale 1ns/1ps

module tb_fetch_line_ctrl;

  localparam int AW = 32;
  localparam int TO = 255;

  logic clk;
  logic reset;

  fetch_line_if #(.ADDR_LEN(AW)) ifc ();

  fetch_line_ctrl #(.ADDR_LEN(AW), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .fl    (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: line buffer contents and the single outstanding request.
  logic          m_v;
  logic [27:0]   m_tag;
  logic [127:0]  m_data;
  logic          m_out;
  logic          m_cancel;
  logic [31:0]   m_addr;
  int            m_wait;
  logic          m_err;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_tag = '0; m_data = '0; m_out = 0; m_cancel = 0;
    m_addr = '0; m_wait = 0; m_err = 0;
  endtask

  task automatic model_step(input logic hitm);
    m_err = 0;
    if (m_out) begin
      if (ifc.mem_ack) begin
        if (!m_cancel) begin
          m_v = 1; m_tag = m_addr[31:4]; m_data = ifc.mem_rdata;
        end
        m_out = 0;
      end else begin
        if (ifc.prmiss || ifc.inv) m_cancel = 1;
`ifdef FETCH_TIMEOUT_EN
        m_wait++;
        if (m_wait == TO) begin
          m_out = 0;
          m_err = 1;
        end
`endif
      end
    end else if (ifc.fetch_en && !hitm && !ifc.prmiss && !ifc.inv) begin
      m_out = 1; m_cancel = 0; m_addr = {ifc.pc[31:4], 4'h0}; m_wait = 0;
    end
    if (ifc.inv) m_v = 0;
  endtask

  task automatic set_in(input logic [31:0] pc, input logic fe, input logic pm,
                        input logic iv, input logic ack, input logic [127:0] rd);
    ifc.pc = pc; ifc.fetch_en = fe; ifc.prmiss = pm; ifc.inv = iv;
    ifc.mem_ack = ack; ifc.mem_rdata = rd;
  endtask

  // One clock: check outputs against the model mid-cycle, then advance the model.
  task automatic cycle();
    logic hitm;
    @(negedge clk);
    hitm = m_v && (m_tag == ifc.pc[31:4]) && !ifc.prmiss && !ifc.inv;
    check_val("req", 128'(ifc.mem_req), 128'(m_out));
    if (m_out) check_val("addr", 128'(ifc.mem_addr), 128'(m_addr));
    check_val("valid", 128'(ifc.idata_valid), 128'(hitm));
    if (hitm) check_val("idata", ifc.idata, m_data);
    check_val("err", 128'(ifc.fetch_err), 128'(m_err));
    @(posedge clk);
    if (!reset) model_reset();
    else model_step(hitm);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  localparam logic [127:0] LA = {32{4'hA}};
  localparam logic [127:0] LB = {32{4'hB}};
  localparam logic [127:0] LC = {32{4'hC}};
  localparam logic [127:0] LD = {32{4'hD}};
  localparam logic [127:0] LE = {32{4'hE}};

  initial begin
    int drops;
    int errs;
    int err_at;
    reset = 1'b0;
    set_in(32'h0, 0, 0, 0, 0, '0);
    model_reset();
    #2;
    // Reset state
    check_val("rst_req", 128'(ifc.mem_req), 128'(0));
    check_val("rst_addr", 128'(ifc.mem_addr), 128'(0));
    check_val("rst_idata", ifc.idata, 128'(0));
    check_val("rst_err", 128'(ifc.fetch_err), 128'(0));
    cycle(); cycle();
    reset = 1'b1;
    cycle();

    // Miss then hit
    set_in(32'h1008, 1, 0, 0, 0, '0); cycle();
    check_val("mh_req", 128'(ifc.mem_req), 128'(1));
    check_val("mh_addr", 128'(ifc.mem_addr), 128'(32'h1000));
    cycle();
    set_in(32'h1008, 1, 0, 0, 1, LA); cycle();
    set_in(32'h1008, 1, 0, 0, 0, '0); #1;
    check_val("mh_valid", 128'(ifc.idata_valid), 128'(1));
    check_val("mh_idata", ifc.idata, LA);
    check_val("mh_req_drop", 128'(ifc.mem_req), 128'(0));
    set_in(32'h100C, 1, 0, 0, 0, '0); #1;
    check_val("mh_hit2", 128'(ifc.idata_valid), 128'(1));
    cycle();
    check_val("mh_noreq", 128'(ifc.mem_req), 128'(0));

    // Redirect mid-fetch
    set_in(32'h2000, 1, 0, 0, 0, '0); cycle();
    check_val("rd_req", 128'(ifc.mem_req), 128'(1));
    set_in(32'h2000, 1, 1, 0, 0, '0); cycle();
    set_in(32'h2000, 0, 0, 0, 0, '0); cycle(); cycle();
    set_in(32'h2000, 0, 0, 0, 1, LB); cycle();
    set_in(32'h2000, 0, 0, 0, 0, '0); #1;
    check_val("rd_valid", 128'(ifc.idata_valid), 128'(0));
    check_val("rd_req_drop", 128'(ifc.mem_req), 128'(0));
    set_in(32'h1000, 0, 0, 0, 0, '0); #1;
    check_val("rd_buf_kept", ifc.idata, LA);
    set_in(32'h2000, 1, 0, 0, 0, '0); cycle();
    check_val("rd_new_req", 128'(ifc.mem_req), 128'(1));
    check_val("rd_new_addr", 128'(ifc.mem_addr), 128'(32'h2000));

    // prmiss + ack together still fills; inv + ack together leaves invalid
    set_in(32'h2000, 1, 1, 0, 1, LC); cycle();
    set_in(32'h2000, 0, 0, 0, 0, '0); #1;
    check_val("pm_ack_valid", 128'(ifc.idata_valid), 128'(1));
    check_val("pm_ack_idata", ifc.idata, LC);
    set_in(32'h3000, 1, 0, 0, 0, '0); cycle();
    set_in(32'h3000, 1, 0, 1, 1, LD); cycle();
    set_in(32'h3000, 0, 0, 0, 0, '0); #1;
    check_val("inv_ack_valid", 128'(ifc.idata_valid), 128'(0));
    set_in(32'h2000, 0, 0, 0, 0, '0); #1;
    check_val("inv_old_valid", 128'(ifc.idata_valid), 128'(0));

    // Reset mid-fetch, late ack arrives in IDLE
    set_in(32'h4000, 1, 0, 0, 0, '0); cycle();
    check_val("rm_req", 128'(ifc.mem_req), 128'(1));
    set_in(32'h4000, 0, 0, 0, 0, '0);
    reset = 1'b0; #1; model_reset();
    check_val("rm_req_async", 128'(ifc.mem_req), 128'(0));
    cycle();
    reset = 1'b1;
    set_in(32'h4000, 0, 0, 0, 1, LE); cycle();
    set_in(32'h4000, 0, 0, 0, 0, '0); #1;
    check_val("rm_req_after", 128'(ifc.mem_req), 128'(0));
    check_val("rm_valid", 128'(ifc.idata_valid), 128'(0));
    check_val("rm_nowrite", ifc.idata, 128'(0));

    // Timeout behaviour
    set_in(32'h6000, 1, 0, 0, 0, '0); cycle();
    set_in(32'h6000, 0, 0, 0, 0, '0);
    drops = 0; errs = 0; err_at = 0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 1; i <= 300; i++) begin
      cycle();
      if (ifc.fetch_err) begin errs++; err_at = i; end
    end
    check_val("to_pulses", 128'(errs), 128'(1));
    check_val("to_when", 128'(err_at), 128'(TO));
    check_val("to_req", 128'(ifc.mem_req), 128'(0));
`else
    for (int i = 0; i < 1000; i++) begin
      cycle();
      if (!ifc.mem_req) drops++;
      if (ifc.fetch_err) errs++;
    end
    check_val("to_req_drops", 128'(drops), 128'(0));
    check_val("to_err", 128'(errs), 128'(0));
`endif
    set_in(32'h6000, 0, 0, 0, 1, LA); cycle();
    set_in(32'h6000, 0, 0, 0, 0, '0); cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      set_in(32'h8000 + 32'($urandom_range(0, 3) << 4) + 32'($urandom_range(0, 15)),
             ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 8),
             ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 35), rnd128());
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0; #1; model_reset();
        cycle();
        reset = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
